// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
//   Bank of CHANNELS independent programmable clock dividers, all running on
//   a single system clock. Each channel toggles its o_clk bit every div[n]
//   enabled cycles (period 2*div[n], 50% duty) and can emit a one-cycle tick
//   at each toggle. New divisors are written through a valid/ready port into
//   a per-channel shadow register and only take effect at the channel's next
//   terminal count, so an in-flight half-period always completes unchanged.
//
// Configuration macro:
//   CLK_DIV_BANK_TICK_EN  defined   -> o_tick registered, one pulse per toggle
//                         undefined -> o_tick tied to zero, no tick registers
//
// Parameters:
//   CHANNELS     number of divider channels (1..8)
//   WIDTH        width of every divisor and counter
//   DEFAULT_DIV  half-period divisor loaded into every channel at reset
//
// Ports:
//   i_clk         system clock, all logic on the rising edge
//   i_reset_n     synchronous active-low reset
//   i_enable      per-channel run enable (bit n = channel n)
//   i_load_valid  divisor load request
//   i_load_ch     target channel of the load
//   i_load_div    new half-period divisor (0 is stored as 1)
//   o_load_ready  combinational: low while the target channel has a pending load
//   o_clk         divided clock per channel, registered
//   o_tick        one-cycle pulse at each o_clk toggle, registered
// ---------------------------------------------------------------------------
module clk_div_bank #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 5_000_000
) (
    input  logic                                               i_clk,
    input  logic                                               i_reset_n,
    input  logic [CHANNELS-1:0]                                i_enable,
    input  logic                                               i_load_valid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_load_ch,
    input  logic [WIDTH-1:0]                                   i_load_div,
    output logic                                               o_load_ready,
    output logic [CHANNELS-1:0]                                o_clk,
    output logic [CHANNELS-1:0]                                o_tick
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    // Shadow keeps the raw reset value; the active divisor never holds zero.
    localparam logic [WIDTH-1:0] RST_SHD = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_DIV = (RST_SHD == '0) ? WIDTH'(1) : RST_SHD;

    logic [WIDTH-1:0]    cnt [CHANNELS];
    logic [WIDTH-1:0]    div [CHANNELS];
    logic [WIDTH-1:0]    shd [CHANNELS];
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] clk_q;

    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] xfer;
    logic [CHANNELS-1:0] tc;
    logic [WIDTH-1:0]    load_div_m;

    // Load channel decode; out-of-range channel numbers select nothing.
    always_comb begin
        sel = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            sel[n] = (i_load_ch == CH_W'(n));
        end
    end

    // Ready only blocks a channel that still holds an unapplied divisor.
    assign o_load_ready = ~|(sel & pend);
    assign xfer         = sel & {CHANNELS{i_load_valid & o_load_ready}};
    assign load_div_m   = (i_load_div == '0) ? WIDTH'(1) : i_load_div;

    // Terminal count; '>=' also recovers a counter that overshot its divisor.
    always_comb begin
        tc = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            tc[n] = i_enable[n] && (cnt[n] >= (div[n] - WIDTH'(1)));
        end
    end

    // Per-channel counter, divisor swap and output clock.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int n = 0; n < CHANNELS; n++) begin
                cnt[n] <= '0;
                div[n] <= RST_DIV;
                shd[n] <= RST_SHD;
            end
            pend  <= '0;
            clk_q <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                // xfer implies pend[n]==0, so it never collides with an apply.
                if (xfer[n]) begin
                    shd[n]  <= load_div_m;
                    pend[n] <= 1'b1;
                end
                if (i_enable[n]) begin
                    if (tc[n]) begin
                        cnt[n]   <= '0;
                        clk_q[n] <= ~clk_q[n];
                        if (pend[n]) begin
                            div[n]  <= shd[n];
                            pend[n] <= 1'b0;
                        end
                    end else begin
                        cnt[n] <= cnt[n] + WIDTH'(1);
                    end
                end else if (pend[n]) begin
                    // Idle channel: no half-period to protect, apply at once.
                    div[n]  <= shd[n];
                    cnt[n]  <= '0;
                    pend[n] <= 1'b0;
                end
            end
        end
    end

    assign o_clk = clk_q;

`ifdef CLK_DIV_BANK_TICK_EN
    logic [CHANNELS-1:0] tick_q;

    // Tick marks the cycle on which o_clk has just toggled.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tc;
        end
    end

    assign o_tick = tick_q;
`else
    assign o_tick = '0;
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// ---------------------------------------------------------------------------
// tb_clk_div_bank
//   Directed bench for clk_div_bank with CHANNELS=3 (2-bit load channel, so
//   channel 3 is out of range), WIDTH=16, DEFAULT_DIV=4. Outputs are sampled
//   1 time unit after each rising edge; inputs change at the same point.
//   Cycle numbers below count rising edges after reset release.
// ---------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int unsigned CH = 3;
    localparam int unsigned W  = 16;
    localparam int unsigned DD = 4;

`ifdef CLK_DIV_BANK_TICK_EN
    localparam logic [CH-1:0] TMASK = '1;
`else
    localparam logic [CH-1:0] TMASK = '0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] enable;
    logic          load_valid;
    logic [1:0]    load_ch;
    logic [W-1:0]  load_div;
    logic          load_ready;
    logic [CH-1:0] dclk;
    logic [CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_bank #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DD)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_enable     (enable),
        .i_load_valid (load_valid),
        .i_load_ch    (load_ch),
        .i_load_div   (load_div),
        .o_load_ready (load_ready),
        .o_clk        (dclk),
        .o_tick       (tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [CH-1:0] eclk,
                           input logic [CH-1:0] etick);
        checks++;
        assert (dclk === eclk) else begin
            errors++;
            $error("FAIL %s o_clk got %b expected %b", tag, dclk, eclk);
        end
        checks++;
        assert (tick === (etick & TMASK)) else begin
            errors++;
            $error("FAIL %s o_tick got %b expected %b", tag, tick, etick & TMASK);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic erdy);
        checks++;
        assert (load_ready === erdy) else begin
            errors++;
            $error("FAIL %s o_load_ready got %b expected %b", tag, load_ready, erdy);
        end
    endtask

    initial begin
        logic b;

        // Reset with a load presented; the load must be discarded.
        reset_n    = 1'b0;
        enable     = '0;
        load_valid = 1'b1;
        load_ch    = 2'd0;
        load_div   = W'(2);
        step();
        step();
        step();
        chk_out("reset", 3'b000, 3'b000);
        chk_rdy("reset_rdy", 1'b1);

        // Default divisor 4 on ch0: toggles on cycles 4, 8, 12.
        reset_n    = 1'b1;
        load_valid = 1'b0;
        enable     = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            step();
            b = (((k / 4) % 2) == 1);
            chk_out($sformatf("run_c%0d", k), {2'b00, b}, {2'b00, (k % 4) == 0});
        end

        // Cycle 13 leaves cnt=1; load 2 transfers on cycle 14.
        step();
        chk_out("c13", 3'b001, 3'b000);
        load_valid = 1'b1;
        load_ch    = 2'd0;
        load_div   = W'(2);
        #1;
        chk_rdy("ld2_rdy", 1'b1);
        step();
        load_valid = 1'b0;
        chk_rdy("ld2_pend_c14", 1'b0);
        chk_out("c14", 3'b001, 3'b000);
        step();
        chk_rdy("ld2_pend_c15", 1'b0);
        chk_out("c15", 3'b001, 3'b000);
        // Old half-period of 4 completes on cycle 16, new divisor applied.
        step();
        chk_out("c16", 3'b000, 3'b001);
        chk_rdy("ld2_applied", 1'b1);
        for (int j = 1; j <= 6; j++) begin
            step();
            b = (((j / 2) % 2) == 1);
            chk_out($sformatf("div2_c%0d", 16 + j), {2'b00, b}, {2'b00, (j % 2) == 0});
        end

        // Restore divisor 4 on ch0 (cnt=0, o_clk0=1).
        load_valid = 1'b1;
        load_div   = W'(4);
        step();
        load_valid = 1'b0;
        chk_out("c23", 3'b001, 3'b000);
        step();
        chk_out("c24", 3'b000, 3'b001);
        step();
        chk_out("c25", 3'b000, 3'b000);
        step();
        chk_out("c26", 3'b000, 3'b000);

        // ch0 held at cnt=2 for 10 cycles; meanwhile load 0 into idle ch1.
        enable     = 3'b000;
        load_valid = 1'b1;
        load_ch    = 2'd1;
        load_div   = W'(0);
        #1;
        chk_rdy("ld0_rdy", 1'b1);
        step();
        load_valid = 1'b0;
        chk_rdy("ld0_pend", 1'b0);
        chk_out("hold1", 3'b000, 3'b000);
        step();
        chk_rdy("ld0_idle_apply", 1'b1);
        chk_out("hold2", 3'b000, 3'b000);
        for (int k = 3; k <= 10; k++) begin
            step();
            chk_out($sformatf("hold%0d", k), 3'b000, 3'b000);
        end

        // Re-enable: ch0 reaches cnt=3 then toggles; ch1 toggles every cycle.
        enable = 3'b011;
        step();
        chk_out("re_a", 3'b010, 3'b010);
        step();
        chk_out("re_b", 3'b001, 3'b011);
        step();
        chk_out("re_c", 3'b011, 3'b010);
        step();
        chk_out("re_d", 3'b001, 3'b010);
        step();
        chk_out("re_e", 3'b011, 3'b010);
        step();
        chk_out("re_f", 3'b000, 3'b011);

        // Pending load on ch0, then reset mid-period.
        load_valid = 1'b1;
        load_ch    = 2'd0;
        load_div   = W'(7);
        step();
        load_valid = 1'b0;
        chk_out("pre_rst", 3'b010, 3'b010);
        chk_rdy("pre_rst_pend", 1'b0);
        reset_n = 1'b0;
        step();
        chk_out("mid_rst", 3'b000, 3'b000);
        chk_rdy("mid_rst_rdy0", 1'b1);
        load_ch = 2'd1;
        #1;
        chk_rdy("mid_rst_rdy1", 1'b1);

        // After release both channels are back on divisor 4.
        reset_n = 1'b1;
        enable  = 3'b011;
        load_ch = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_out($sformatf("post_rst_c%0d", k), 3'b000, 3'b000);
        end
        step();
        chk_out("post_rst_c4", 3'b011, 3'b011);

        // Out-of-range channel 3: ready, and no divisor changes.
        load_valid = 1'b1;
        load_ch    = 2'd3;
        load_div   = W'(1);
        #1;
        chk_rdy("oor_rdy", 1'b1);
        step();
        load_valid = 1'b0;
        chk_out("oor_c5", 3'b011, 3'b000);
        load_ch = 2'd0;
        #1;
        chk_rdy("oor_rdy_ch0", 1'b1);
        step();
        chk_out("oor_c6", 3'b011, 3'b000);
        step();
        chk_out("oor_c7", 3'b011, 3'b000);
        step();
        chk_out("oor_c8", 3'b000, 3'b011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
